// File: rtl/store_buffer_pkg.sv
// Shared controller/memory-op encodings and drain FSM states for the store buffer.
// Forwarding is built only when STORE_FWD_EN is defined (see store_fifo).
package store_buffer_pkg;

    localparam logic [2:0] STATE_FETCH   = 3'd0;
    localparam logic [2:0] STATE_DECODE  = 3'd1;
    localparam logic [2:0] STATE_EXECUTE = 3'd2;
    localparam logic [2:0] STATE_MEM     = 3'd3;
    localparam logic [2:0] STATE_WB      = 3'd4;

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Data-memory write port: req/ack handshake carrying one byte write.
// The store buffer is the master; the data memory is the slave.
interface store_buffer_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/store_buffer_fifo.sv
// store_fifo: pending-store storage, pointers, occupancy and the youngest-match
// address search used for load forwarding (present only with STORE_FWD_EN).
module store_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [7:0]        push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              none,
    output logic [ADDR_W-1:0] head_addr,
    output logic [7:0]        head_data,
    output logic [ADDR_W-1:0] next_addr,
    output logic [7:0]        next_data,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [7:0]        lookup_data
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [7:0]        data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             pop_ok;

    assign pop_ok     = pop && (count_reg != '0);
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    always_comb begin
        count_next = count_reg;
        case ({push, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_next;
        end
    end

    // Payload needs no reset: validity is defined solely by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign none  = (count_reg == '0);

    // Bypass the push port when the wanted entry is only being written this edge.
    assign head_addr = (count_reg == '0)        ? push_addr : addr_mem[rd_ptr_reg];
    assign head_data = (count_reg == '0)        ? push_data : data_mem[rd_ptr_reg];
    assign next_addr = (count_reg == CNT_W'(1)) ? push_addr : addr_mem[rd_ptr_inc];
    assign next_data = (count_reg == CNT_W'(1)) ? push_data : data_mem[rd_ptr_inc];

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] age_match;
    logic [7:0]       age_data [DEPTH];

    // Index by age (0 = oldest) so the last hit in the scan is the youngest.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [PTR_W-1:0] slot;
        assign slot          = rd_ptr_reg + PTR_W'(gi);
        assign age_match[gi] = (CNT_W'(gi) < count_reg) && (addr_mem[slot] == lookup_addr);
        assign age_data[gi]  = data_mem[slot];
    end

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                lookup_hit  = 1'b1;
                lookup_data = age_data[i];
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_addr;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: captures STATE_MEM writes into store_fifo and drains
// them in order over a req/ack port. STORE_FWD_EN enables store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state,
    input  logic [1:0]        operation,
    input  logic [31:0]       address,
    input  logic [7:0]        store_value,
    output logic              stall,
    output logic              empty,
    store_buffer_if.master    mem,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [7:0]        lookup_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              store_req;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              none;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        next_data;
    logic              remain_after_pop;

    drain_state_t      drain_reg, drain_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;

    logic unused_addr;
    assign unused_addr = ^address[31:ADDR_W];

    // Fullness is judged on the registered count, so a same-cycle pop never admits a push.
    assign store_req = (state == STATE_MEM) && (operation == MEM_WRITE);
    assign push      = store_req && !full;
    assign stall     = store_req && full;

    store_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (address[ADDR_W-1:0]),
        .push_data   (store_value),
        .pop         (pop),
        .count       (count),
        .full        (full),
        .none        (none),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .next_addr   (next_addr),
        .next_data   (next_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    assign remain_after_pop = (count > CNT_W'(1)) || push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_reg <= DRAIN_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            drain_reg <= drain_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // The entry under request stays in the FIFO until acked, so forwarding still sees it.
    always_comb begin
        drain_next = drain_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        pop        = 1'b0;
        case (drain_reg)
            DRAIN_IDLE: begin
                if (!none || push) begin
                    drain_next = DRAIN_REQ;
                    addr_next  = head_addr;
                    wdata_next = head_data;
                end
            end
            DRAIN_REQ: begin
                if (mem.mem_ack) begin
                    pop = 1'b1;
                    if (remain_after_pop) begin
                        addr_next  = next_addr;
                        wdata_next = next_data;
                    end else begin
                        drain_next = DRAIN_IDLE;
                    end
                end
            end
            default: drain_next = DRAIN_IDLE;
        endcase
    end

    assign mem.mem_req   = (drain_reg == DRAIN_REQ);
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign empty         = none && (drain_reg == DRAIN_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores are queued as expected writes
// and checked in order against each acked memory write.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        state;
    logic [1:0]        operation;
    logic [31:0]       address;
    logic [7:0]        store_value;
    logic              stall;
    logic              empty;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [7:0]        lookup_data;

    store_buffer_if #(.ADDR_W(ADDR_W)) mem_if ();

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .operation   (operation),
        .address     (address),
        .store_value (store_value),
        .stall       (stall),
        .empty       (empty),
        .mem         (mem_if),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] exp_q[$];

    // One clock: observe the write port mid-cycle, then step to just after the edge.
    task automatic tick();
        logic [15:0] exp;
        @(negedge clk);
        if (mem_if.mem_req && mem_if.mem_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL write_order: unexpected write addr=%0h data=%0h, none required",
                         mem_if.mem_addr, mem_if.mem_wdata);
            end else begin
                exp = exp_q.pop_front();
                if ({mem_if.mem_addr, mem_if.mem_wdata} !== exp) begin
                    n_fails++;
                    $display("FAIL write_order: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             mem_if.mem_addr, mem_if.mem_wdata, exp[15:8], exp[7:0]);
                end else
                    $display("write addr=%0h data=%0h ok", mem_if.mem_addr, mem_if.mem_wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        state     = STATE_FETCH;
        operation = MEM_NONE;
    endtask

    task automatic set_store(input logic [7:0] a, input logic [7:0] v);
        state       = STATE_MEM;
        operation   = MEM_WRITE;
        address     = {24'hABCDEF, a};
        store_value = v;
    endtask

    // Store expected to be accepted this cycle (buffer not full).
    task automatic do_store(input logic [7:0] a, input logic [7:0] v);
        set_store(a, v);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fails++;
            $display("FAIL store_stall: stall=%b, required 0", stall);
        end
        exp_q.push_back({a, v});
        tick();
    endtask

    task automatic drain();
        int c;
        mem_if.mem_ack = 1'b1;
        set_idle();
        c = 0;
        while (!(empty && exp_q.size() == 0) && c < 30) begin
            tick();
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0 || empty !== 1'b1) begin
            n_fails++;
            $display("FAIL drain: pending=%0d empty=%b, required pending=0 empty=1", exp_q.size(), empty);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata, empty, stall, lookup_hit} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_state: req=%b addr=%0h wdata=%0h empty=%b stall=%b hit=%b, required 0 0 0 1 0 0",
                     mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata, empty, stall, lookup_hit);
        end
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_single_store();
        mem_if.mem_ack = 1'b1;
        do_store(8'd2, 8'h03);
        set_idle();
        n_checks++;
        if ({mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 8'd2, 8'h03}) begin
            n_fails++;
            $display("FAIL single_req: req=%b addr=%0h wdata=%0h, required 1 2 03",
                     mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata);
        end
        tick();
        n_checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL single_empty: empty=%b pending=%0d, required 1 0", empty, exp_q.size());
        end
    endtask

    task automatic test_fill();
        mem_if.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++)
            do_store(8'(i), 8'h40 + 8'(i));
        set_store(8'd4, 8'h44);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fails++;
            $display("FAIL fill_stall: stall=%b on 5th store, required 1", stall);
        end
        mem_if.mem_ack = 1'b1;
        tick();
        n_checks++;
        if (stall !== 1'b0) begin
            n_fails++;
            $display("FAIL fill_release: stall=%b after one pop, required 0", stall);
        end
        exp_q.push_back({8'd4, 8'h44});
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        mem_if.mem_ack = 1'b0;
        do_store(8'h55, 8'hA5);
        set_idle();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b1, 8'h55, 8'hA5}) begin
                n_fails++;
                $display("FAIL backpressure_hold: cycle %0d req=%b addr=%0h wdata=%0h, required 1 55 a5",
                         i, mem_if.mem_req, mem_if.mem_addr, mem_if.mem_wdata);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        mem_if.mem_ack = 1'b0;
        do_store(8'h10, 8'hB0);
        do_store(8'h11, 8'hB1);
        mem_if.mem_ack = 1'b1;
        do_store(8'h12, 8'hB2);
        set_idle();
        n_checks++;
        if (dut.u_fifo.count_reg !== 3'd2) begin
            n_fails++;
            $display("FAIL push_pop_count: count=%0d, required 2", dut.u_fifo.count_reg);
        end
        tick();
        tick();
        n_checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL throughput: empty=%b pending=%0d after 2 cycles, required 1 0", empty, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_req();
        mem_if.mem_ack = 1'b0;
        do_store(8'h20, 8'hC0);
        do_store(8'h21, 8'hC1);
        do_store(8'h22, 8'hC2);
        set_idle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_if.mem_req !== 1'b0 || empty !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_mid_req: req=%b empty=%b, required 0 1", mem_if.mem_req, empty);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        mem_if.mem_ack = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (mem_if.mem_req !== 1'b0 || empty !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_release: req=%b empty=%b, required 0 1", mem_if.mem_req, empty);
        end
    endtask

    task automatic test_forward();
        logic       exp_hit;
        logic [7:0] exp_data;
        mem_if.mem_ack = 1'b0;
        do_store(8'd1, 8'h11);
        do_store(8'd1, 8'h22);
        set_idle();
        lookup_addr = 8'd1;
        #1;
`ifdef STORE_FWD_EN
        exp_hit = 1'b1; exp_data = 8'h22;
`else
        exp_hit = 1'b0; exp_data = 8'h00;
`endif
        n_checks++;
        if (lookup_hit !== exp_hit || lookup_data !== exp_data) begin
            n_fails++;
            $display("FAIL fwd_youngest: hit=%b data=%0h, required %b %0h", lookup_hit, lookup_data, exp_hit, exp_data);
        end
        set_store(8'd9, 8'h99);
        lookup_addr = 8'd9;
        #1;
        n_checks++;
        if (lookup_hit !== 1'b0) begin
            n_fails++;
            $display("FAIL fwd_same_cycle: hit=%b for in-flight push, required 0", lookup_hit);
        end
        exp_q.push_back({8'd9, 8'h99});
        tick();
        set_idle();
`ifdef STORE_FWD_EN
        exp_hit = 1'b1; exp_data = 8'h99;
`endif
        n_checks++;
        if (lookup_hit !== exp_hit || lookup_data !== exp_data) begin
            n_fails++;
            $display("FAIL fwd_after_push: hit=%b data=%0h, required %b %0h", lookup_hit, lookup_data, exp_hit, exp_data);
        end
        lookup_addr = 8'd3;
        #1;
        n_checks++;
        if (lookup_hit !== 1'b0) begin
            n_fails++;
            $display("FAIL fwd_miss: hit=%b for unmatched address, required 0", lookup_hit);
        end
        drain();
    endtask

    initial begin
        set_idle();
        address        = '0;
        store_value    = '0;
        lookup_addr    = '0;
        mem_if.mem_ack = 1'b0;
        test_reset();
        test_single_store();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_req();
        test_forward();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
